// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: ALU control code width and op encodings shared with the EX stage
package alu_share_arb_pkg;
    localparam int ALU_CTRL_W = 4;
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;
endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant, pointer held by the parent
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    // a lone requester wins outright; on contention the favoured one wins
    always_comb grant = (valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one EX ALU between pipeline issue and aux unit via issue/result registers
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [XLEN-1:0]       req0_a,
    input  logic [XLEN-1:0]       req0_b,
    input  logic [ALU_CTRL_W-1:0] req0_ctrl,
    input  logic [TAG_W-1:0]      req0_tag,
    input  logic [XLEN-1:0]       req1_a,
    input  logic [XLEN-1:0]       req1_b,
    input  logic [ALU_CTRL_W-1:0] req1_ctrl,
    input  logic [TAG_W-1:0]      req1_tag,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]       alu_result,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [XLEN-1:0]       rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy
);
    logic                  s1_valid, s1_owner;
    logic [XLEN-1:0]       s1_a, s1_b;
    logic [ALU_CTRL_W-1:0] s1_ctrl;
    logic [TAG_W-1:0]      s1_tag;
    logic                  s2_valid, s2_owner;
    logic [XLEN-1:0]       s2_data;
    logic [TAG_W-1:0]      s2_tag;
    logic                  rr_ptr, g, accept, s2_free, s1_adv, s1_free;
    logic [1:0]            gnt;

    rr_arb2 u_arb (.valid(req_valid), .ptr(rr_ptr), .grant(gnt));

    assign rsp_valid = {s2_valid & s2_owner, s2_valid & ~s2_owner};
    assign s2_free   = !s2_valid | (rsp_valid[s2_owner] & rsp_ready[s2_owner]);
    assign s1_adv    = s1_valid & s2_free;
    assign s1_free   = !s1_valid | s1_adv;
    assign req_ready = s1_free ? gnt : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign g         = gnt[1];
    // the ALU sees zeros whenever the issue register is empty
    assign alu_a     = s1_valid ? s1_a : '0;
    assign alu_b     = s1_valid ? s1_b : '0;
    assign alu_ctrl  = s1_valid ? s1_ctrl : '0;
    assign rsp_data  = s2_data;
    assign rsp_tag   = s2_tag;
    assign busy      = s1_valid | s2_valid;

    // issue and result registers; drain, advance and accept may all land on one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_owner <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_owner <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= 1'b1;
                s2_owner <= s1_owner;
                s2_data  <= alu_result;
                s2_tag   <= s1_tag;
            end else if (s2_free) begin
                s2_valid <= 1'b0;
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_owner <= g;
                s1_a     <= g ? req1_a : req0_a;
                s1_b     <= g ? req1_b : req0_b;
                s1_ctrl  <= g ? req1_ctrl : req0_ctrl;
                s1_tag   <= g ? req1_tag : req0_tag;
                rr_ptr   <= ~g;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single EX-stage ALU between two requesters: req0 is the main pipeline EX issue, req1 is the auxiliary branch-target / address unit.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Two-stage pipeline: an issue register drives the shared ALU, and a result register returns the result to its owner.
- Sits between the ID/EX control path and the ALU. It drives the ALU operands and the 4-bit ALU control code, and captures the ALU result.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 5, requester-supplied tag width (e.g. rd index), returned unchanged with the result

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready at the edge
- req0_a, req0_b  in  XLEN each  requester 0 operands
- req0_ctrl  in  4  requester 0 ALU control code (package encoding)
- req0_tag  in  TAG_W  requester 0 tag
- req1_a, req1_b, req1_ctrl, req1_tag  in  as req0  requester 1 fields
- alu_a, alu_b  out  XLEN  operands to the shared ALU (from the issue register)
- alu_ctrl  out  4  control code to the shared ALU
- alu_result  in  XLEN  combinational ALU result for alu_a/alu_b/alu_ctrl
- rsp_valid  out  2  result valid, bit i = owner i
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  XLEN  registered result
- rsp_tag  out  TAG_W  tag of the returned result
- busy  out  1  high when either pipeline register holds a valid entry

Behaviour:
- State:
  - S1 (issue register): valid, owner, a, b, ctrl, tag.
  - S2 (result register): valid, owner, result, tag.
  - rr_ptr: 1 bit, the favoured requester.
- Reset (rst=1 at edge):
  - S1.valid=0, S2.valid=0, rr_ptr=0; all data fields zero.
  - Outputs after reset: req_ready=2'b00 only if no request is pending (see grant below), rsp_valid=0, rsp_data=0, rsp_tag=0, alu_a=alu_b=0, alu_ctrl=4'b0000, busy=0.
  - Reset mid-operation discards every in-flight entry; no response is ever produced for it.
- Advance conditions:
  - s2_free = !S2.valid | (rsp_valid[S2.owner] & rsp_ready[S2.owner]).
  - s1_adv = S1.valid & s2_free.
  - s1_free = !S1.valid | s1_adv.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - req_ready[g] = s1_free; the non-granted ready bit is 0.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Accept from requester g:
  - S1 loads g's fields, owner=g, valid=1.
  - rr_ptr <= ~g.
  - rr_ptr is unchanged when no accept occurs.
- S1 -> S2 on s1_adv: S2 <= {1, S1.owner, alu_result, S1.tag}. S1.valid clears unless a new accept happens on the same edge.
- S2 drains when rsp_ready[owner] is high; it clears unless refilled on the same edge.
- Simultaneous events: a response drain, an S1 advance and a new accept can all happen on one edge. Full throughput is 1 op/cycle.
- Latency: accept at edge E0 -> rsp_valid visible after E0+2 edges, provided the response side is not stalled.
- Backpressure:
  - If S2 is stalled, S1 holds, alu_* stay stable, and req_ready=0.
  - At most 2 ops are in flight.
- Ordering: responses are returned in acceptance order. Each requester observes its own results in order.
- rsp_data/rsp_tag are held stable while rsp_valid is high and not yet accepted.
- alu_a/alu_b/alu_ctrl come straight from S1 fields and are zero when S1 is empty, so the ALU sees no spurious operands.
- busy = S1.valid | S2.valid.

Decomposition:
- Shared package (RISCV_PKG): the ALU control code width (4) and the ALU op code constants (ADD, SUB, XOR, ...). No new op codes are needed.
- Sub-module rr_arb2: 2-way round-robin grant. Inputs valid[1:0], ptr; output one-hot grant. Pure combinational; the pointer register stays in the parent.

Test Plan:
- Reset held 2 cycles with req_valid=2'b11 -> rsp_valid=0, busy=0, alu_ctrl=0. First accept after reset goes to req0 (rr_ptr=0).
- Single op on req0: a=7, b=5, ctrl=ADD, tag=3, rsp_ready=1 -> rsp_valid[0]=1 exactly 2 edges after accept, rsp_data=12, rsp_tag=3.
- Both valid continuously for 6 cycles, rsp_ready=2'b11 -> grants alternate 0,1,0,1,0,1 and one response per cycle in the same order. Example: req1 SUB 10-3 -> 7.
- Backpressure:
  - Hold rsp_ready[0]=0 with S2 owned by 0 -> S1 fills and req_ready=00.
  - alu_a/alu_b stay constant while stalled.
  - Release -> the two results drain on consecutive cycles with none lost.
- Only req1 valid while rr_ptr=0 -> req1 is granted immediately (no idle bubble) and rr_ptr becomes 0 after the accept.
- Assert rst with both S1 and S2 full -> the next cycle has rsp_valid=0 and busy=0, and no stale result appears afterwards.
